// File: rtl/enc83_arb_if.sv
// enc83_arb_if: request/acknowledge bundle between event sources and the
// shared service port.
//   master: drives req_0..req_7, mask, en, ack; observes a/b/c, valid, pend
//   slave : the arbiter side (receives requests, presents the code)
interface enc83_arb_if;
  logic       req_0;
  logic       req_1;
  logic       req_2;
  logic       req_3;
  logic       req_4;
  logic       req_5;
  logic       req_6;
  logic       req_7;
  logic [7:0] mask;   // bit i = 1 blocks selection of request i
  logic       en;     // active-low enable for new presentations
  logic       ack;    // consumer acknowledge of the presented code
  logic       a;      // presented index bit 0
  logic       b;      // presented index bit 1
  logic       c;      // presented index bit 2
  logic       valid;  // a/b/c hold a valid code
  logic [7:0] pend;   // pending-request register

  modport master (
    output req_0, req_1, req_2, req_3, req_4, req_5, req_6, req_7,
    output mask, en, ack,
    input  a, b, c, valid, pend
  );

  modport slave (
    input  req_0, req_1, req_2, req_3, req_4, req_5, req_6, req_7,
    input  mask, en, ack,
    output a, b, c, valid, pend
  );
endinterface

// File: rtl/enc83_arb.sv
// enc83_arb: registered 8-to-3 priority encoder with pending-request latch
// and acknowledge handshake. Request strobes are captured into pend; the
// lowest-numbered unmasked pending request is presented as {c,b,a} with
// valid until the consumer acknowledges it.
//
// Ports:
//   sys_clk - system clock, all state changes on its rising edge
//   resetl  - asynchronous active-low reset
//   bus     - enc83_arb_if slave modport (requests, mask, en, ack in;
//             a/b/c, valid, pend out)
// Parameter:
//   EDGE    - 1: capture rising edges of req; 0: capture while req is high
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | nothing presented, valid = 0, looking for an enabled candidate
// PRESENT | code frozen on a/b/c with valid = 1, waiting for ack
module enc83_arb #(
  parameter bit EDGE = 1'b1
) (
  input logic         sys_clk,
  input logic         resetl,
  enc83_arb_if.slave  bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] req;
  logic [7:0] prev;
  logic [7:0] pend_q;
  logic [2:0] code_q;
  logic       valid_q;

  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] pend_nxt;
  logic [7:0] cand;
  logic       cand_any;
  logic [2:0] sel_idx;

  assign req = {bus.req_7, bus.req_6, bus.req_5, bus.req_4,
                bus.req_3, bus.req_2, bus.req_1, bus.req_0};

  // prev resets to 0, so a request already high at reset release counts
  // as an edge in EDGE mode.
  assign rise = EDGE ? (req & ~prev) : req;

  // Clear only the presented index, and only on an ack that the consumer
  // could legitimately give (valid high).
  always_comb begin
    clr = '0;
    if ((state == PRESENT) && valid_q && bus.ack) begin
      clr[code_q] = 1'b1;
    end
  end

  // Set wins over clear so a new event arriving with the ack is not lost.
  assign pend_nxt = (pend_q & ~clr) | rise;

  // Selection works from the registered pend, keeping every output a pure
  // register with no input-to-output combinational path.
  assign cand     = pend_q & ~bus.mask;
  assign cand_any = |cand;

  always_comb begin
    sel_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) begin
        sel_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state   <= IDLE;
      prev    <= '0;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prev   <= req;
      pend_q <= pend_nxt;
      case (state)
        IDLE: begin
          if (!bus.en && cand_any) begin
            code_q  <= sel_idx;
            valid_q <= 1'b1;
            state   <= PRESENT;
          end else begin
            valid_q <= 1'b0;
          end
        end
        PRESENT: begin
          // No preemption: mask/en changes leave the code in place.
          if (bus.ack) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.a     = code_q[0];
  assign bus.b     = code_q[1];
  assign bus.c     = code_q[2];
  assign bus.valid = valid_q;
  assign bus.pend  = pend_q;

endmodule

// File: tb/tb_enc83_arb.sv
module tb_enc83_arb;

  logic sys_clk = 1'b0;
  logic resetl  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 sys_clk = ~sys_clk;

  enc83_arb_if bus_e ();
  enc83_arb_if bus_l ();

  enc83_arb #(.EDGE(1'b1)) dut_e (.sys_clk(sys_clk), .resetl(resetl), .bus(bus_e));
  enc83_arb #(.EDGE(1'b0)) dut_l (.sys_clk(sys_clk), .resetl(resetl), .bus(bus_l));

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req_e(input logic [7:0] v);
    {bus_e.req_7, bus_e.req_6, bus_e.req_5, bus_e.req_4,
     bus_e.req_3, bus_e.req_2, bus_e.req_1, bus_e.req_0} = v;
  endtask

  task automatic set_req_l(input logic [7:0] v);
    {bus_l.req_7, bus_l.req_6, bus_l.req_5, bus_l.req_4,
     bus_l.req_3, bus_l.req_2, bus_l.req_1, bus_l.req_0} = v;
  endtask

  // Checks valid plus the presented code on the edge-mode instance.
  task automatic chk_pres_e(input string tag, input logic v, input logic [2:0] code);
    chk({tag, "_valid"}, 32'(bus_e.valid), 32'(v));
    chk({tag, "_code"}, 32'({bus_e.c, bus_e.b, bus_e.a}), 32'(code));
  endtask

  initial begin
    logic [7:0] exp_pend;

    set_req_e(8'h00); bus_e.mask = 8'h00; bus_e.en = 1'b0; bus_e.ack = 1'b0;
    set_req_l(8'h00); bus_l.mask = 8'h00; bus_l.en = 1'b0; bus_l.ack = 1'b0;
    #23;
    chk_pres_e("reset", 1'b0, 3'd0);
    chk("reset_pend", 32'(bus_e.pend), 32'h00);
    resetl = 1'b1;
    tick();

    // Single request on line 5
    set_req_e(8'h20);
    tick();
    chk("single_pend", 32'(bus_e.pend), 32'h20);
    chk("single_nov", 32'(bus_e.valid), 32'h0);
    set_req_e(8'h00);
    tick();
    chk_pres_e("single_pres", 1'b1, 3'd5);
    bus_e.mask = 8'hFF; bus_e.en = 1'b1;
    tick();
    chk_pres_e("single_hold", 1'b1, 3'd5);
    bus_e.mask = 8'h00; bus_e.en = 1'b0; bus_e.ack = 1'b1;
    tick();
    chk_pres_e("single_ack", 1'b0, 3'd5);
    chk("single_ack_pend", 32'(bus_e.pend), 32'h00);
    bus_e.ack = 1'b0;

    // Priority, no preemption by lower index
    set_req_e(8'h40);
    tick();
    set_req_e(8'h00);
    tick();
    chk_pres_e("prio_6", 1'b1, 3'd6);
    set_req_e(8'h02);
    tick();
    chk_pres_e("prio_hold6", 1'b1, 3'd6);
    chk("prio_pend", 32'(bus_e.pend), 32'h42);
    set_req_e(8'h00); bus_e.ack = 1'b1;
    tick();
    chk("prio_gap", 32'(bus_e.valid), 32'h0);
    chk("prio_gap_pend", 32'(bus_e.pend), 32'h02);
    bus_e.ack = 1'b0;
    tick();
    chk_pres_e("prio_1", 1'b1, 3'd1);
    bus_e.ack = 1'b1;
    tick();
    bus_e.ack = 1'b0;
    chk("prio_clear", 32'(bus_e.pend), 32'h00);

    // Mask blocks selection, not capture; ack while idle is ignored
    bus_e.mask = 8'h04; set_req_e(8'h04);
    tick();
    set_req_e(8'h00);
    tick();
    tick();
    chk("mask_nov", 32'(bus_e.valid), 32'h0);
    chk("mask_pend", 32'(bus_e.pend), 32'h04);
    bus_e.ack = 1'b1;
    tick();
    chk("idle_ack_pend", 32'(bus_e.pend), 32'h04);
    bus_e.ack = 1'b0; bus_e.mask = 8'h00;
    tick();
    chk_pres_e("unmask", 1'b1, 3'd2);
    bus_e.ack = 1'b1;
    tick();
    bus_e.ack = 1'b0;

    // Enable gating, then simultaneous set and clear on index 3
    bus_e.en = 1'b1; set_req_e(8'h08);
    tick();
    set_req_e(8'h00);
    tick();
    tick();
    chk("en_nov", 32'(bus_e.valid), 32'h0);
    chk("en_pend", 32'(bus_e.pend), 32'h08);
    bus_e.en = 1'b0;
    tick();
    chk_pres_e("en_pres", 1'b1, 3'd3);
    set_req_e(8'h08); bus_e.ack = 1'b1;
    tick();
    chk("setclr_gap", 32'(bus_e.valid), 32'h0);
    chk("setclr_pend", 32'(bus_e.pend), 32'h08);
    set_req_e(8'h00); bus_e.ack = 1'b0;
    tick();
    chk_pres_e("setclr_repres", 1'b1, 3'd3);
    bus_e.ack = 1'b1;
    tick();
    bus_e.ack = 1'b0;
    chk("setclr_done", 32'(bus_e.pend), 32'h00);

    // Burst of all eight with ack held high
    set_req_e(8'hFF);
    tick();
    chk("burst_pend", 32'(bus_e.pend), 32'hFF);
    set_req_e(8'h00); bus_e.ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_pres_e($sformatf("burst_pres%0d", k), 1'b1, 3'(k));
      tick();
      exp_pend = 8'hFF << (k + 1);
      chk($sformatf("burst_gap%0d", k), 32'(bus_e.valid), 32'h0);
      chk($sformatf("burst_pend%0d", k), 32'(bus_e.pend), 32'(exp_pend));
    end
    bus_e.ack = 1'b0;

    // Level mode: held request re-presented after each ack
    set_req_l(8'h10);
    tick();
    chk("lvl_pend", 32'(bus_l.pend), 32'h10);
    tick();
    chk("lvl_pres", 32'({bus_l.valid, bus_l.c, bus_l.b, bus_l.a}), 32'hC);
    bus_l.ack = 1'b1;
    tick();
    chk("lvl_gap", 32'(bus_l.valid), 32'h0);
    bus_l.ack = 1'b0;
    tick();
    chk("lvl_repres", 32'({bus_l.valid, bus_l.c, bus_l.b, bus_l.a}), 32'hC);
    bus_l.ack = 1'b1;
    tick();
    chk("lvl_gap2", 32'(bus_l.valid), 32'h0);
    bus_l.ack = 1'b0;
    tick();
    chk("lvl_repres2", 32'({bus_l.valid, bus_l.c, bus_l.b, bus_l.a}), 32'hC);

    // Asynchronous reset mid-presentation
    set_req_e(8'h80);
    tick();
    set_req_e(8'h00);
    tick();
    chk_pres_e("pre_rst", 1'b1, 3'd7);
    #2;
    resetl = 1'b0;
    #1;
    chk_pres_e("async_rst", 1'b0, 3'd0);
    chk("async_rst_pend", 32'(bus_e.pend), 32'h00);
    chk("async_rst_lvl", 32'({bus_l.valid, bus_l.pend}), 32'h000);

    // Request already high at reset release counts as an edge
    set_req_l(8'h00);
    set_req_e(8'h01);
    #10;
    resetl = 1'b1;
    tick();
    chk("rel_edge_pend", 32'(bus_e.pend), 32'h01);
    set_req_e(8'h00);
    tick();
    chk_pres_e("rel_edge_pres", 1'b1, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
